// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan controller with frame-aligned load/ack.
// Optional LEADING_ZERO_BLANK_EN turns off anodes of leading zero digits.
module seg_scan_ctrl #(
   parameter int REFRESH_DIV = 100000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] bcd_in,
   input  logic        load,
   output logic        load_ack,
   output logic [3:0]  led_bcd,
   output logic [3:0]  an
);

   localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);

   logic [PW-1:0] r_presc;
   logic [1:0]    r_idx;
   logic [15:0]   r_disp;
   logic [15:0]   r_shd;
   logic          r_pend;
   logic          r_ack;
   logic [3:0]    r_led;
   logic [3:0]    r_an;

   logic          w_tick;
   logic          w_wrap;
   logic [PW-1:0] w_presc_nxt;
   logic [1:0]    w_idx_nxt;
   logic [15:0]   w_disp_nxt;
   logic [15:0]   w_shd_nxt;
   logic          w_pend_nxt;
   logic          w_ack_nxt;
   logic [3:0]    w_led_nxt;
   logic [3:0]    w_an_nxt;
   logic          w_blank;

   assign w_tick = (r_presc == P_LAST);
   assign w_wrap = w_tick && (r_idx == 2'd3);

   // Next-state: slot stepping, shadow capture and frame-aligned transfer
   always_comb begin
      w_presc_nxt = w_tick ? '0 : r_presc + PW'(1);
      w_idx_nxt   = w_tick ? r_idx + 2'd1 : r_idx;
      w_shd_nxt   = load ? bcd_in : r_shd;
      w_pend_nxt  = r_pend | load;
      w_disp_nxt  = r_disp;
      w_ack_nxt   = 1'b0;
      if (w_wrap) begin
         if (load) begin
            w_disp_nxt = bcd_in;
            w_pend_nxt = 1'b0;
            w_ack_nxt  = 1'b1;
         end else if (r_pend) begin
            w_disp_nxt = r_shd;
            w_pend_nxt = 1'b0;
            w_ack_nxt  = 1'b1;
         end
      end
   end

   // Output decode from next-state digit index and display value
   always_comb begin
      w_led_nxt = w_disp_nxt[4*w_idx_nxt +: 4];
      w_blank   = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      unique case (w_idx_nxt)
         2'd3:    w_blank = (w_disp_nxt[15:12] == 4'h0);
         2'd2:    w_blank = (w_disp_nxt[15:8] == 8'h00);
         2'd1:    w_blank = (w_disp_nxt[15:4] == 12'h000);
         default: w_blank = 1'b0;
      endcase
`endif
      w_an_nxt = w_blank ? 4'b1111 : ~(4'b0001 << w_idx_nxt);
   end

   // State and registered outputs, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_presc <= '0;
         r_idx   <= 2'd0;
         r_disp  <= 16'h0000;
         r_shd   <= 16'h0000;
         r_pend  <= 1'b0;
         r_ack   <= 1'b0;
         r_led   <= 4'h0;
         r_an    <= 4'b1111;
      end else begin
         r_presc <= w_presc_nxt;
         r_idx   <= w_idx_nxt;
         r_disp  <= w_disp_nxt;
         r_shd   <= w_shd_nxt;
         r_pend  <= w_pend_nxt;
         r_ack   <= w_ack_nxt;
         r_led   <= w_led_nxt;
         r_an    <= w_an_nxt;
      end
   end

   assign load_ack = r_ack;
   assign led_bcd  = r_led;
   assign an       = r_an;

endmodule
